// File: rtl/round_robin_arbiter.sv
// round_robin_arbiter: registered round-robin arbiter with a sticky valid/ready grant
module round_robin_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_aresetn,
  input  logic [N-1:0]    i_req,
  input  logic            i_ready,
  output logic [N-1:0]    o_gnt,
  output logic [IDXW-1:0] o_gnt_idx,
  output logic            o_valid
);
  logic [N-1:0]    gnt_q, gnt_d, masked, sel, cand;
  logic [IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d, cand_idx;
  logic            valid_q, valid_d, hs, load;
  // Advance the pointer past an accepted grant and pick the next candidate with it, so back-to-back grants stay fair
  always_comb begin
    hs       = valid_q & i_ready;
    load     = !valid_q | i_ready;
    ptr_d    = hs ? ((idx_q == IDXW'(N-1)) ? '0 : idx_q + 1'b1) : ptr_q;
    masked   = '0;
    for (int k = 0; k < N; k++) masked[k] = i_req[k] & (k >= int'(ptr_d));
    sel      = (|masked) ? masked : i_req;
    cand     = sel & (~sel + 1'b1);
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) cand_idx = sel[k] ? IDXW'(k) : cand_idx;
    gnt_d    = load ? cand : gnt_q;
    idx_d    = load ? cand_idx : idx_q;
    valid_d  = load ? |i_req : valid_q;
  end
  // Grant and priority state; reset drops any in-flight grant and restores requester 0 as highest priority
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end
  assign o_gnt     = gnt_q;
  assign o_gnt_idx = idx_q;
  assign o_valid   = valid_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// tb_round_robin_arbiter: scoreboard bench for round_robin_arbiter with directed vectors
module tb_round_robin_arbiter;
  logic       clk = 0, rst_n = 1, ready = 0;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic [1:0] idx;
  logic       valid;
  int         errors = 0, checks = 0;
  typedef struct {logic [3:0] g; logic [1:0] i;} exp_t;
  exp_t       q[$];

  round_robin_arbiter #(.N(4)) dut (
    .i_clk(clk), .i_aresetn(rst_n), .i_req(req), .i_ready(ready),
    .o_gnt(gnt), .o_gnt_idx(idx), .o_valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] i);
    exp_t e;
    e.g = g;
    e.i = i;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every offered grant with the queue head, retire it on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        if (q.size() == 0) chk("unexpected_grant", {28'd0, gnt}, 32'd0);
        else begin
          chk("gnt", {28'd0, gnt}, {28'd0, q[0].g});
          chk("gnt_idx", {30'd0, idx}, {30'd0, q[0].i});
          if (ready) void'(q.pop_front());
        end
      end else begin
        chk("idle_gnt_zero", {28'd0, gnt}, 32'd0);
        chk("idle_idx_zero", {30'd0, idx}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 0;
    step(); step();
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_gnt", {28'd0, gnt}, 32'd0);
    rst_n = 1;
    ready = 1;
    push(4'b0001, 0); push(4'b0010, 1); push(4'b0100, 2);
    push(4'b1000, 3); push(4'b0001, 0); push(4'b0010, 1);
    repeat (6) step();
    ready = 0;
    req = 4'b0000;
    step();
    req = 4'b1001;
    step(); step();
    chk("hold_valid", {31'd0, valid}, 32'd1);
    ready = 1;
    push(4'b1000, 3);
    step();
    req = 4'b0100;
    push(4'b0100, 2);
    step();
    req = 4'b0011;
    push(4'b0001, 0);
    step();
    push(4'b0010, 1);
    step();
    req = 4'b0000;
    step();
    chk("idle_valid", {31'd0, valid}, 32'd0);
    req = 4'b0100;
    push(4'b0100, 2);
    step();
    ready = 0;
    req = 4'b1111;
    step();
    chk("held_before_reset", {31'd0, valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("async_valid", {31'd0, valid}, 32'd0);
    chk("async_gnt", {28'd0, gnt}, 32'd0);
    chk("async_idx", {30'd0, idx}, 32'd0);
    if (q.size() > 0) void'(q.pop_front());
    step();
    rst_n = 1;
    ready = 1;
    push(4'b0001, 0);
    step();
    req = 4'b0000;
    for (int n = 0; n < 20 && q.size() > 0; n++) step();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
